// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the two-source UART transmit arbiter.
// Used by uart_tx_arb and its optional statistics counters.
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } tx_arb_state_t;

    localparam logic SRC_CMD = 1'b0;
    localparam logic SRC_SMP = 1'b1;

    // Starvation counter width covers STARVE_MAX up to 255.
    localparam int STARVE_W = 8;
    localparam int STAT_W   = 16;

    // Priority rule: cmd wins unless smp is waiting and has been passed over STARVE_MAX times.
    function automatic logic pick_smp(
        input logic                cmd_stb,
        input logic                smp_stb,
        input logic [STARVE_W-1:0] starve_cnt,
        input logic [STARVE_W-1:0] starve_lim
    );
        return smp_stb & (~cmd_stb | (starve_cnt == starve_lim));
    endfunction

endpackage

// File: rtl/uart_tx_arb_sat_cnt.sv
// Saturating event counter used for the optional accept statistics.
// Holds at all-ones once reached; cleared only by reset.
module uart_tx_arb_sat_cnt #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;
    logic         w_full;

    assign w_full = &r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_inc && !w_full) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/uart_tx_arb.sv
// Shares one uart_tx between a high-priority command path and a low-priority sample path.
// Define UART_TX_ARB_STATS_EN to add saturating accept counters cnt_cmd_o / cnt_smp_o.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              xoff_i,
    input  logic              cmd_stb_i,
    input  logic [WORD_W-1:0] cmd_data_i,
    output logic              cmd_rdy_o,
    input  logic              smp_stb_i,
    input  logic [WORD_W-1:0] smp_data_i,
    output logic              smp_rdy_o,
    output logic              tx_stb_o,
    output logic [WORD_W-1:0] tx_data_o,
    input  logic              tx_rdy_i,
    output logic              busy_o,
    output logic              src_o
`ifdef UART_TX_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] cnt_cmd_o,
    output logic [STAT_W-1:0] cnt_smp_o
`endif
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    tx_arb_state_t       r_state;
    tx_arb_state_t       w_state_next;
    logic [STARVE_W-1:0] r_starve;
    logic [WORD_W-1:0]   r_tx_data;
    logic                r_src;

    logic                w_grant;
    logic                w_sel_smp;
    logic                w_cmd_acc;
    logic                w_smp_acc;

    // Acks are suppressed during reset so a requester never sees an accept that reset discards.
    assign w_grant   = (r_state == IDLE) & tx_rdy_i & ~xoff_i
                     & (cmd_stb_i | smp_stb_i) & ~rst_i;
    assign w_sel_smp = pick_smp(cmd_stb_i, smp_stb_i, r_starve, STARVE_LIM);
    assign w_cmd_acc = w_grant & ~w_sel_smp;
    assign w_smp_acc = w_grant &  w_sel_smp;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (w_grant)   w_state_next = ISSUE;
            ISSUE:                    w_state_next = WAIT_ACK;
            WAIT_ACK:  if (!tx_rdy_i) w_state_next = WAIT_DONE;
            WAIT_DONE: if (tx_rdy_i)  w_state_next = IDLE;
            default:                  w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The granted word is latched once and held for the whole transmitter busy cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tx_data <= '0;
            r_src     <= SRC_CMD;
        end else if (w_grant) begin
            r_tx_data <= w_sel_smp ? smp_data_i : cmd_data_i;
            r_src     <= w_sel_smp ? SRC_SMP : SRC_CMD;
        end
    end

    // Counts cmd wins while smp is kept waiting; any idle smp cycle forgives the history.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_starve <= '0;
        end else if (!smp_stb_i || w_smp_acc) begin
            r_starve <= '0;
        end else if (w_cmd_acc && (r_starve != STARVE_LIM)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    assign cmd_rdy_o = w_cmd_acc;
    assign smp_rdy_o = w_smp_acc;
    assign tx_stb_o  = (r_state == ISSUE);
    assign tx_data_o = r_tx_data;
    assign busy_o    = (r_state != IDLE);
    assign src_o     = r_src;

`ifdef UART_TX_ARB_STATS_EN
    uart_tx_arb_sat_cnt #(
        .W (STAT_W)
    ) u_cnt_cmd (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_inc (w_cmd_acc),
        .o_cnt (cnt_cmd_o)
    );

    uart_tx_arb_sat_cnt #(
        .W (STAT_W)
    ) u_cnt_smp (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_inc (w_smp_acc),
        .o_cnt (cnt_smp_o)
    );
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed plus randomized bench for uart_tx_arb against a transaction-level reference model.
// Honours UART_TX_ARB_STATS_EN to also check the accept counters.
module tb_uart_tx_arb;

    localparam int W  = 32;
    localparam int SM = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         xoff;
    logic         cmd_stb;
    logic [W-1:0] cmd_data;
    logic         smp_stb;
    logic [W-1:0] smp_data;
    logic         tx_rdy;
    logic         cmd_rdy;
    logic         smp_rdy;
    logic         tx_stb;
    logic [W-1:0] tx_data;
    logic         busy;
    logic         src;
`ifdef UART_TX_ARB_STATS_EN
    logic [15:0]  cnt_cmd;
    logic [15:0]  cnt_smp;
    int           m_ncmd = 0;
    int           m_nsmp = 0;
`endif

    always #5 clk = ~clk;

    uart_tx_arb #(
        .WORD_W     (W),
        .STARVE_MAX (SM)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .xoff_i     (xoff),
        .cmd_stb_i  (cmd_stb),
        .cmd_data_i (cmd_data),
        .cmd_rdy_o  (cmd_rdy),
        .smp_stb_i  (smp_stb),
        .smp_data_i (smp_data),
        .smp_rdy_o  (smp_rdy),
        .tx_stb_o   (tx_stb),
        .tx_data_o  (tx_data),
        .tx_rdy_i   (tx_rdy),
        .busy_o     (busy),
        .src_o      (src)
`ifdef UART_TX_ARB_STATS_EN
        ,
        .cnt_cmd_o  (cnt_cmd),
        .cnt_smp_o  (cnt_smp)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Requester word queues: stb is high while a queue holds a word.
    logic [W-1:0] cq[$];
    logic [W-1:0] sq[$];
    bit           cmd_en = 1'b1;
    bit           smp_en = 1'b1;

    // Reference model: a word granted at cycle g strobes at g+1 and frees the arbiter at g+3+L,
    // where L is the number of cycles the transmitter model holds rdy low.
    int           cyc      = 0;
    bit           m_busy   = 1'b0;
    int           m_stb    = -10;
    int           m_done   = 0;
    int           m_starve = 0;
    logic         m_src    = 1'b0;
    logic [W-1:0] m_data   = '0;
    bit           u_act    = 1'b0;
    int           u_stb    = 0;
    int           u_len    = 0;
    int           force_len = 0;
    bit           last_grant = 1'b0;
    logic         d_cmd_rdy, d_smp_rdy;
    logic         gsrc_log[$];
    int           dut_acks;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        bit           grant, sel, idle;
        int           len;
        cmd_stb  = cmd_en && (cq.size() > 0);
        cmd_data = cmd_stb ? cq[0] : '0;
        smp_stb  = smp_en && (sq.size() > 0);
        smp_data = smp_stb ? sq[0] : '0;
        tx_rdy   = !(u_act && cyc >= u_stb + 1 && cyc <= u_stb + u_len);
        @(negedge clk);
        if (m_busy && cyc >= m_done) m_busy = 1'b0;
        idle  = !m_busy;
        grant = idle && tx_rdy && !xoff && (cmd_stb || smp_stb) && !rst;
        sel   = smp_stb && (!cmd_stb || m_starve == SM);
        d_cmd_rdy = cmd_rdy;
        d_smp_rdy = smp_rdy;
        if (cmd_rdy === 1'b1 || smp_rdy === 1'b1) dut_acks++;
        chk("cmd_rdy", W'(cmd_rdy), W'(grant && !sel));
        chk("smp_rdy", W'(smp_rdy), W'(grant && sel));
        chk("tx_stb",  W'(tx_stb),  W'(m_busy && cyc == m_stb));
        chk("busy",    W'(busy),    W'(m_busy));
        chk("src",     W'(src),     W'(m_src));
        chk("tx_data", tx_data, m_data);
`ifdef UART_TX_ARB_STATS_EN
        chk("cnt_cmd", W'(cnt_cmd), W'(m_ncmd));
        chk("cnt_smp", W'(cnt_smp), W'(m_nsmp));
`endif
        last_grant = grant;
        if (grant) begin
            len    = (force_len != 0) ? force_len : int'($urandom_range(1, 4));
            m_busy = 1'b1;
            m_stb  = cyc + 1;
            m_done = cyc + 3 + len;
            u_act  = 1'b1;
            u_stb  = cyc + 1;
            u_len  = len;
            m_src  = sel;
            m_data = sel ? smp_data : cmd_data;
            gsrc_log.push_back(sel);
            $display("cyc=%0d grant src=%0d data=%h L=%0d", cyc, sel, m_data, len);
            if (sel) void'(sq.pop_front());
            else     void'(cq.pop_front());
`ifdef UART_TX_ARB_STATS_EN
            if (sel) begin if (m_nsmp < 65535) m_nsmp++; end
            else     begin if (m_ncmd < 65535) m_ncmd++; end
`endif
        end
        if (rst || !smp_stb || (grant && sel)) m_starve = 0;
        else if (grant && m_starve < SM)       m_starve++;
        if (rst) begin
            m_busy = 1'b0;
            m_src  = 1'b0;
            m_data = '0;
`ifdef UART_TX_ARB_STATS_EN
            m_ncmd = 0;
            m_nsmp = 0;
`endif
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_grant(input string tag);
        for (int i = 0; i < 60; i++) begin
            step();
            if (last_grant) return;
        end
        chk(tag, 0, 1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (n < 3000 && (cq.size() > 0 || sq.size() > 0 || m_busy)) begin
            step();
            n++;
        end
        chk(tag, W'(cq.size() + sq.size() + int'(m_busy)), 0);
        repeat (2) step();
    endtask

    initial begin
        logic [W-1:0] wb;
        logic         exp_order [7];
        int           t0;

        rst = 1'b1; xoff = 1'b0; cmd_stb = 1'b0; smp_stb = 1'b0;
        cmd_data = '0; smp_data = '0; tx_rdy = 1'b1;
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        step();
        $display("reset state checked");

        // Single cmd word
        cq.push_back(32'hDEADBEEF);
        t0 = cyc;
        wait_grant("t1_grant");
        chk("t1_accept_cycle", W'(cyc - 1), W'(t0));
        chk("t1_cmd_rdy", W'(d_cmd_rdy), 1);
        step();
        chk("t1_tx_data", tx_data, 32'hDEADBEEF);
        drain("t1_drain");

        // Starvation guard with both pending from the same cycle
        gsrc_log.delete();
        for (int i = 0; i < 4; i++) cq.push_back(32'hC000_0000 + W'(i));
        for (int i = 0; i < 3; i++) sq.push_back(32'h5000_0000 + W'(i));
        drain("t2_drain");
        exp_order = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        chk("t2_grant_count", W'(gsrc_log.size()), 7);
        for (int i = 0; i < 7 && i < gsrc_log.size(); i++)
            chk($sformatf("t2_order%0d", i), W'(gsrc_log[i]), W'(exp_order[i]));

        // XOFF blocks a pending sample word
        xoff = 1'b1;
        sq.push_back(32'h12345678);
        dut_acks = 0;
        repeat (100) step();
        chk("t3_no_ack_xoff", W'(dut_acks), 0);
        xoff = 1'b0;
        step();
        chk("t3_release_ack", W'(d_smp_rdy), 1);
        drain("t3_drain");

        // XOFF raised one cycle after the strobe: word completes, next word held
        cq.push_back(32'hAAAA0001);
        cq.push_back(32'hAAAA0002);
        wait_grant("t4_grant");
        step();
        xoff = 1'b1;
        dut_acks = 0;
        repeat (20) step();
        chk("t4_no_ack_xoff", W'(dut_acks), 0);
        chk("t4_idle_after", W'(busy), 0);
        xoff = 1'b0;
        drain("t4_drain");

        // Reset during WAIT_DONE: word lost, next word accepted normally
        force_len = 3;
        wb = 32'hBBBB0002;
        cq.push_back(32'hBBBB0001);
        cq.push_back(wb);
        wait_grant("t5_grant");
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        force_len = 0;
        chk("t5_busy_rst", W'(busy), 0);
        chk("t5_data_rst", tx_data, 0);
        chk("t5_src_rst",  W'(src), 0);
        wait_grant("t5_regrant");
        chk("t5_next_word", m_data, wb);
        drain("t5_drain");

        // Randomized traffic with random XOFF and requester gating
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) cq.push_back($urandom);
            if ($urandom_range(0, 4) == 0) sq.push_back($urandom);
            xoff   = ($urandom_range(0, 7) == 0);
            cmd_en = ($urandom_range(0, 9) != 0);
            smp_en = ($urandom_range(0, 9) != 0);
            step();
        end
        xoff = 1'b0; cmd_en = 1'b1; smp_en = 1'b1;
        drain("t6_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
